// File: rtl/alu_op_sequencer_pkg.sv
// Shared widths, FSM encoding and command record for the ALU operation sequencer.
// Every file in this slice takes its widths and encodings from here.
package alu_op_sequencer_pkg;

  localparam int DATA_W                 = 8;
  localparam int MODE_W                 = 3;
  localparam int RES_W                  = 16;
  localparam int CMD_W                  = MODE_W + 2 * DATA_W;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  localparam int FIFO_DEPTH_DEFAULT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } alu_cmd_t;

  function automatic alu_cmd_t pack_cmd(input logic [MODE_W-1:0] mode,
                                        input logic [DATA_W-1:0] op1,
                                        input logic [DATA_W-1:0] op2);
    alu_cmd_t c;
    c.mode = mode;
    c.op1  = op1;
    c.op2  = op2;
    return c;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response buses of the sequencer bundled as one interface.
// Operands and results are two's complement; the wires themselves are plain vectors.
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [MODE_W-1:0] cmd_mode_i;
  logic [DATA_W-1:0] cmd_op1_i;
  logic [DATA_W-1:0] cmd_op2_i;

  logic [DATA_W-1:0] alu_op1_o;
  logic [DATA_W-1:0] alu_op2_o;
  logic [MODE_W-1:0] alu_mode_o;
  logic              alu_valid_o;
  logic [RES_W-1:0]  alu_res_i;
  logic              alu_valid_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [RES_W-1:0]  rsp_res_o;
  logic              rsp_err_o;

  logic              busy_o;

  // Sequencer side
  modport slave (
    input  cmd_valid_i, cmd_mode_i, cmd_op1_i, cmd_op2_i,
    output cmd_ready_o,
    output alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o,
    input  alu_res_i, alu_valid_i,
    output rsp_valid_o, rsp_res_o, rsp_err_o,
    input  rsp_ready_i,
    output busy_o
  );

  // Environment side: command producer, ALU and response consumer
  modport master (
    output cmd_valid_i, cmd_mode_i, cmd_op1_i, cmd_op2_i,
    input  cmd_ready_o,
    input  alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o,
    output alu_res_i, alu_valid_i,
    input  rsp_valid_o, rsp_res_o, rsp_err_o,
    output rsp_ready_i,
    input  busy_o
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; the head entry is always visible on dout.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, issues them one at a time, and returns each result
// (or a timeout error) through a valid/ready response port.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [DATA_W-1:0] alu_op1_reg, alu_op1_next;
  logic [DATA_W-1:0] alu_op2_reg, alu_op2_next;
  logic [MODE_W-1:0] alu_mode_reg, alu_mode_next;
  logic [RES_W-1:0]  rsp_res_reg, rsp_res_next;
  logic              rsp_err_reg, rsp_err_next;

  alu_cmd_t cmd_in;
  alu_cmd_t head_cmd;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     load_issue;

  assign cmd_in    = pack_cmd(bus.cmd_mode_i, bus.cmd_op1_i, bus.cmd_op2_i);
  assign fifo_push = bus.cmd_valid_i && !fifo_full;
  assign fifo_pop  = (state_reg == ST_ISSUE);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cmd_in),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      alu_op1_reg  <= '0;
      alu_op2_reg  <= '0;
      alu_mode_reg <= '0;
      rsp_res_reg  <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      alu_op1_reg  <= alu_op1_next;
      alu_op2_reg  <= alu_op2_next;
      alu_mode_reg <= alu_mode_next;
      rsp_res_reg  <= rsp_res_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    alu_op1_next  = alu_op1_reg;
    alu_op2_next  = alu_op2_reg;
    alu_mode_next = alu_mode_reg;
    rsp_res_next  = rsp_res_reg;
    rsp_err_next  = rsp_err_reg;
    load_issue    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_ISSUE;
          load_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving in the limit cycle takes priority over the timeout
        if (bus.alu_valid_i) begin
          rsp_res_next = bus.alu_res_i;
          rsp_err_next = 1'b0;
          state_next   = ST_RESP;
        end else if (wait_cnt_reg == CNT_LIMIT) begin
          rsp_res_next = '0;
          rsp_err_next = 1'b1;
          state_next   = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          if (!fifo_empty) begin
            state_next = ST_ISSUE;
            load_issue = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Operands are captured on the edge entering ISSUE so they are registered during it
    if (load_issue) begin
      alu_op1_next  = head_cmd.op1;
      alu_op2_next  = head_cmd.op2;
      alu_mode_next = head_cmd.mode;
    end
  end

  assign bus.cmd_ready_o = !fifo_full;
  assign bus.alu_op1_o   = alu_op1_reg;
  assign bus.alu_op2_o   = alu_op2_reg;
  assign bus.alu_mode_o  = alu_mode_reg;
  assign bus.alu_valid_o = (state_reg == ST_ISSUE);
  assign bus.rsp_valid_o = (state_reg == ST_RESP);
  assign bus.rsp_res_o   = rsp_res_reg;
  assign bus.rsp_err_o   = rsp_err_reg;
  assign bus.busy_o      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: single op, timeout, limit-cycle result,
// spurious strobes, back-pressured burst with slow consumer, and mid-operation reset.
module tb_alu_op_sequencer;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0]  tm [5];
  logic [7:0]  t1 [5];
  logic [7:0]  t2 [5];
  logic [15:0] texp [5];

  initial begin
    logic               bad;
    int                 issued;
    int                 got;
    logic               pend;
    logic signed [15:0] prod;

    tm[0] = 3'd2; t1[0] = 8'd1;   t2[0] = 8'd3;   texp[0] = 16'h0003;
    tm[1] = 3'd2; t1[1] = 8'd2;   t2[1] = 8'hFC;  texp[1] = 16'hFFF8;
    tm[2] = 3'd5; t1[2] = 8'd5;   t2[2] = 8'd5;   texp[2] = 16'h0019;
    tm[3] = 3'd6; t1[3] = 8'hF9;  t2[3] = 8'd2;   texp[3] = 16'hFFF2;
    tm[4] = 3'd7; t1[4] = 8'h64;  t2[4] = 8'd3;   texp[4] = 16'h012C;

    bus.cmd_valid_i = 1'b0;
    bus.cmd_mode_i  = '0;
    bus.cmd_op1_i   = '0;
    bus.cmd_op2_i   = '0;
    bus.alu_res_i   = '0;
    bus.alu_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready",     bus.cmd_ready_o, 1);
    check("rst_alu_valid", bus.alu_valid_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_busy",      bus.busy_o, 0);
    check("rst_alu_op1",   bus.alu_op1_o, 0);
    check("rst_rsp_res",   bus.rsp_res_o, 0);
    rst = 1'b0;
    tick();

    // Single command 16+2, ALU answers 18 three cycles after issue
    bus.cmd_valid_i = 1'b1; bus.cmd_mode_i = 3'd0; bus.cmd_op1_i = 8'd16; bus.cmd_op2_i = 8'd2;
    tick();
    bus.cmd_valid_i = 1'b0;
    check("t1_no_early_issue", bus.alu_valid_o, 0);
    check("t1_busy",           bus.busy_o, 1);
    tick();
    check("t1_issue_n2", bus.alu_valid_o, 1);
    check("t1_op1",      bus.alu_op1_o, 16);
    check("t1_op2",      bus.alu_op2_o, 2);
    check("t1_mode",     bus.alu_mode_o, 0);
    tick();
    check("t1_issue_one_cycle", bus.alu_valid_o, 0);
    check("t1_op1_hold",        bus.alu_op1_o, 16);
    tick();
    tick();
    bus.alu_valid_i = 1'b1; bus.alu_res_i = 16'd18;
    tick();
    bus.alu_valid_i = 1'b0;
    check("t1_rsp_valid", bus.rsp_valid_o, 1);
    check("t1_rsp_res",   bus.rsp_res_o, 18);
    check("t1_rsp_err",   bus.rsp_err_o, 0);
    tick();
    check("t1_rsp_held",  bus.rsp_valid_o, 1);
    check("t1_res_held",  bus.rsp_res_o, 18);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("t1_rsp_drop", bus.rsp_valid_o, 0);
    check("t1_idle",     bus.busy_o, 0);

    // Timeout: no ALU answer
    bus.cmd_valid_i = 1'b1; bus.cmd_mode_i = 3'd1; bus.cmd_op1_i = 8'd5; bus.cmd_op2_i = 8'd6;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    check("to_issue", bus.alu_valid_o, 1);
    tick();
    bad = 1'b0;
    for (int i = 1; i < T; i++) begin
      tick();
      bad = bad | bus.rsp_valid_o;
    end
    check("to_not_early", bad, 0);
    tick();
    check("to_rsp_valid", bus.rsp_valid_o, 1);
    check("to_rsp_err",   bus.rsp_err_o, 1);
    check("to_rsp_res",   bus.rsp_res_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("to_rsp_drop", bus.rsp_valid_o, 0);

    // Result in the timeout-limit cycle wins
    bus.cmd_valid_i = 1'b1; bus.cmd_mode_i = 3'd3; bus.cmd_op1_i = 8'h80; bus.cmd_op2_i = 8'd1;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    tick();
    bad = 1'b0;
    for (int i = 1; i < T; i++) begin
      tick();
      bad = bad | bus.rsp_valid_o;
    end
    check("lim_not_early", bad, 0);
    bus.alu_valid_i = 1'b1; bus.alu_res_i = 16'hFF80;
    tick();
    bus.alu_valid_i = 1'b0;
    check("lim_rsp_valid", bus.rsp_valid_o, 1);
    check("lim_rsp_err",   bus.rsp_err_o, 0);
    check("lim_rsp_res",   bus.rsp_res_o, 16'hFF80);

    // Spurious strobe while holding a response
    bus.alu_valid_i = 1'b1; bus.alu_res_i = 16'h1234;
    tick();
    bus.alu_valid_i = 1'b0;
    check("spr_resp_valid", bus.rsp_valid_o, 1);
    check("spr_resp_res",   bus.rsp_res_o, 16'hFF80);
    check("spr_resp_err",   bus.rsp_err_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("spr_resp_drop", bus.rsp_valid_o, 0);

    // Spurious strobe while idle
    bus.alu_valid_i = 1'b1; bus.alu_res_i = 16'h1234;
    tick();
    bus.alu_valid_i = 1'b0;
    check("spi_rsp_valid", bus.rsp_valid_o, 0);
    check("spi_busy",      bus.busy_o, 0);
    check("spi_res_held",  bus.rsp_res_o, 16'hFF80);
    tick();
    check("spi_rsp_valid2", bus.rsp_valid_o | bus.alu_valid_o, 0);

    // Five back-to-back commands, ALU answers a product, consumer ready every 4th cycle
    issued = 0;
    got    = 0;
    pend   = 1'b0;
    prod   = '0;
    for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
      if (cyc < 5) begin
        bus.cmd_valid_i = 1'b1;
        bus.cmd_mode_i  = tm[cyc];
        bus.cmd_op1_i   = t1[cyc];
        bus.cmd_op2_i   = t2[cyc];
      end else if (cyc <= 8) begin
        // Offered while full, including the cycle in which the head is popped
        bus.cmd_valid_i = 1'b1;
        bus.cmd_mode_i  = 3'd7;
        bus.cmd_op1_i   = 8'd99;
        bus.cmd_op2_i   = 8'd99;
      end else begin
        bus.cmd_valid_i = 1'b0;
      end
      if (cyc == 5) check("bb_full_after_4", bus.cmd_ready_o, 0);
      if (cyc == 8) check("bb_full_on_pop",  bus.cmd_ready_o, 0);

      bus.alu_valid_i = 1'b0;
      if (pend) begin
        bus.alu_valid_i = 1'b1;
        bus.alu_res_i   = prod;
        pend            = 1'b0;
      end
      if (bus.alu_valid_o) begin
        if (issued < 5) begin
          check("bb_issue_op1",  bus.alu_op1_o, t1[issued]);
          check("bb_issue_op2",  bus.alu_op2_o, t2[issued]);
          check("bb_issue_mode", bus.alu_mode_o, tm[issued]);
        end
        prod = $signed(bus.alu_op1_o) * $signed(bus.alu_op2_o);
        pend = 1'b1;
        issued++;
      end

      bus.rsp_ready_i = (cyc % 4 == 3);
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (got < 5) begin
          check("bb_rsp_res", bus.rsp_res_o, texp[got]);
          check("bb_rsp_err", bus.rsp_err_o, 0);
        end
        got++;
      end
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    bus.alu_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    check("bb_rsp_count", got, 5);
    check("bb_issued",    issued, 5);
    check("bb_busy_done", bus.busy_o, 0);
    tick();
    check("bb_no_sixth", bus.alu_valid_o, 0);

    // Reset during WAIT with two commands buffered
    bus.cmd_valid_i = 1'b1;
    bus.cmd_mode_i = 3'd1; bus.cmd_op1_i = 8'd1; bus.cmd_op2_i = 8'd1;
    tick();
    bus.cmd_mode_i = 3'd2; bus.cmd_op1_i = 8'd2; bus.cmd_op2_i = 8'd2;
    tick();
    check("rw_issue", bus.alu_valid_o, 1);
    bus.cmd_mode_i = 3'd3; bus.cmd_op1_i = 8'd3; bus.cmd_op2_i = 8'd3;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    check("rw_waiting", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_busy",      bus.busy_o, 0);
    check("rw_ready",     bus.cmd_ready_o, 1);
    check("rw_alu_op1",   bus.alu_op1_o, 0);
    check("rw_alu_mode",  bus.alu_mode_o, 0);
    check("rw_rsp_res",   bus.rsp_res_o, 0);
    check("rw_rsp_valid", bus.rsp_valid_o, 0);
    bus.alu_valid_i = 1'b1; bus.alu_res_i = 16'h5A5A;
    tick();
    bus.alu_valid_i = 1'b0;
    check("rw_late_rsp", bus.rsp_valid_o, 0);
    check("rw_late_res", bus.rsp_res_o, 0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bad = bad | bus.alu_valid_o | bus.rsp_valid_o | bus.busy_o;
    end
    check("rw_quiet", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
